neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of the Q6.10 operands and result.
REQ-002 SHALL have parameter FRAC_BITS, default 10, the number of fractional bits per operand.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, the accumulator width.
REQ-004 SHALL have parameter MAX_LEN, default 1024, the maximum beats per dot product (range 1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: begins a dot product, sampled only in IDLE.
REQ-008 SHALL have port bias_in, input, DATA_WIDTH, signed Q6.10: bias, latched with start.
REQ-009 SHALL have port valid_in, input, 1: operand beat valid.
REQ-010 SHALL have port data_in, input, DATA_WIDTH, signed Q6.10: activation operand.
REQ-011 SHALL have port weight_in, input, DATA_WIDTH, signed Q6.10: weight operand.
REQ-012 SHALL have port last_in, input, 1: marks the final beat, qualified by valid_in.
REQ-013 SHALL have port ready_in, output, 1: high exactly when in ACCUM.
REQ-014 SHALL have port busy, output, 1: high whenever not in IDLE.
REQ-015 SHALL have port valid_out, output, 1: one-cycle result strobe, which drives the tanh stage directly.
REQ-016 SHALL have port data_out, output, DATA_WIDTH, signed Q6.10: the result.
REQ-017 SHALL have port sat_flag, output, 1: result was clamped; valid only with valid_out.
REQ-018 SHALL have port len_err, output, 1: the MAX_LEN guard forced completion; valid only with valid_out.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, SCALE, with reset state IDLE.
REQ-020 IDLE SHALL take start=1 as follows: acc <= sign_extend(bias_in) << FRAC_BITS, beat_cnt <= 0, next state ACCUM; start=0 SHALL keep IDLE.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 valid_in SHALL be ignored outside ACCUM, with no accumulator change.
REQ-023 ACCUM SHALL take valid_in=1 as follows: acc <= acc + sign_extend(data_in*weight_in), a full 2*DATA_WIDTH-bit signed product in Q12.20, and beat_cnt <= beat_cnt+1.
REQ-024 ACCUM with valid_in=0 SHALL hold all state; gaps of any length SHALL be permitted.
REQ-025 ACCUM SHALL go to SCALE after the beat with last_in=1, or after the beat that makes beat_cnt equal MAX_LEN; the latter case SHALL set len_err and, if last_in=1 on that same beat, len_err SHALL stay 0.
REQ-026 acc SHALL wrap modulo 2^ACC_WIDTH; wrap SHALL not be detected.
REQ-027 SCALE SHALL compute r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, an arithmetic shift giving round-half-up.
REQ-028 SCALE SHALL clamp r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. 0x8000..0x7FFF, and set sat_flag=1 if clamped.
REQ-029 SCALE SHALL register data_out, assert valid_out for exactly one cycle, and return to IDLE.
REQ-030 Latency SHALL be as follows: for a last beat accepted at edge N, valid_out is high during the cycle after edge N+1.
REQ-031 data_out SHALL hold its value until the next result; sat_flag and len_err SHALL clear when valid_out deasserts.
REQ-032 The earliest next start SHALL be the cycle in which valid_out is high, since the FSM is IDLE then; back-to-back operation SHALL be supported.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL set state IDLE, acc 0, beat_cnt 0, valid_out 0, data_out 0x0000, sat_flag 0, len_err 0, ready_in 0, busy 0.
REQ-034 rst asserted mid-ACCUM or in SCALE SHALL abort the operation with no valid_out pulse; the partial sum SHALL be discarded.
REQ-035 rst SHALL have priority over start and valid_in in the same cycle.

Verification
REQ-036 Basic: bias 0x0400, beats (0x0800,0x0200), (0x0400,0xFC00,last) -> data_out 0x0400, valid_out exactly one cycle, 2 cycles after the last beat, sat_flag 0.
REQ-037 Saturation: bias 0x7FFF, beat (0x7FFF,0x7FFF,last) -> 0x7FFF with sat_flag 1; bias 0, beat (0x8000,0x7FFF,last) -> 0x8000 with sat_flag 1.
REQ-038 Rounding: bias 0, beat (0x0001,0x0200,last) -> 0x0001; beat (0x0001,0xFE00,last) -> 0x0000.
REQ-039 Gaps and ignore: valid_in pulses in IDLE are ignored, and a start with bias 0 and beats (0x0400,0x0400) separated by 3 idle cycles, then (0x0400,0x0400,last) -> 0x0800; start pulses during ACCUM have no effect.
REQ-040 Length guard: MAX_LEN=4, bias 0, 4 beats of (0x0400,0x0400) with last_in=0 -> data_out 0x1000, len_err 1; a 5th beat is ignored (ready_in 0).
REQ-041 Reset mid-op: rst for 1 cycle after 2 of 3 beats -> no valid_out, busy 0; a new start with bias 0x0000 and beat (0x0000,0x0000,last) -> 0x0000.

Source files
------------

// File: rtl/neuron_mac.sv
// neuron_mac: signed Q6.10 multiply-accumulate with bias, round-half-up
// rescale and saturation. Results feed the tanh stage via a one-cycle strobe.
module neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_LEN    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bias_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic                  last_in,
  output logic                  ready_in,
  output logic                  busy,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sat_flag,
  output logic                  len_err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int PW    = 2 * DATA_WIDTH;
  // Width of the rescaled accumulator (one guard bit for the rounding add).
  localparam int RW    = ACC_WIDTH + 1 - FRAC_BITS;

  localparam logic [CNT_W-1:0]       MAX_C = CNT_W'(MAX_LEN);
  localparam logic signed [ACC_WIDTH:0] HALF =
    {{(ACC_WIDTH + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
  localparam logic signed [RW-1:0] MAXV =
    {{(RW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {{(RW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    lerr_q, lerr_d;
  logic                    vout_q, vout_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    sat_q, sat_d;
  logic                    len_q, len_d;

  logic signed [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0]        prod_ext, bias_ext;
  logic [CNT_W-1:0]            cnt_nxt;
  logic signed [ACC_WIDTH:0]   rnd;
  logic signed [RW-1:0]        r;
  logic [DATA_WIDTH-1:0]       clamped;
  logic                        sat_c;

  assign prod     = $signed(data_in) * $signed(weight_in);
  assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
  // Bias is Q6.10; shift into the Q12.20 accumulator domain.
  assign bias_ext = {{(ACC_WIDTH - DATA_WIDTH - FRAC_BITS){bias_in[DATA_WIDTH-1]}},
                     bias_in, {FRAC_BITS{1'b0}}};
  assign cnt_nxt  = cnt_q + CNT_W'(1);

  // Round-half-up then drop the fractional bits (floor of the biased sum).
  assign rnd = $signed({acc_q[ACC_WIDTH-1], acc_q}) + HALF;
  assign r   = rnd[ACC_WIDTH:FRAC_BITS];

  // Saturate the rescaled value into the output range.
  always_comb begin
    clamped = r[DATA_WIDTH-1:0];
    sat_c   = 1'b0;
    if (r > MAXV) begin
      clamped = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      sat_c   = 1'b1;
    end else if (r < MINV) begin
      clamped = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      sat_c   = 1'b1;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lerr_d  = lerr_q;
    vout_d  = 1'b0;
    sat_d   = 1'b0;
    len_d   = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          lerr_d  = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (valid_in) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_nxt;
          if (last_in) begin
            lerr_d  = 1'b0;
            state_d = SCALE;
          end else if (cnt_nxt == MAX_C) begin
            // Guard tripped before the producer marked the end.
            lerr_d  = 1'b1;
            state_d = SCALE;
          end
        end
      end
      SCALE: begin
        vout_d  = 1'b1;
        dout_d  = clamped;
        sat_d   = sat_c;
        len_d   = lerr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      lerr_q  <= 1'b0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lerr_q  <= lerr_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
      len_q   <= len_d;
    end
  end

  assign ready_in  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign sat_flag  = sat_q;
  assign len_err   = len_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed cases plus randomized dot products checked
// against an arithmetic reference model.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst, start, valid_in, last_in;
  logic [15:0] bias_in, data_in, weight_in;

  logic        rdy, bsy, vo, sat, lerr;
  logic [15:0] dout;
  logic        rdy4, bsy4, vo4, sat4, lerr4;
  logic [15:0] dout4;

  int errors = 0;
  int checks = 0;

  logic [15:0] md[0:15];
  logic [15:0] mw[0:15];

  always #5 clk = ~clk;

  neuron_mac u_dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .valid_in(valid_in), .data_in(data_in), .weight_in(weight_in),
    .last_in(last_in), .ready_in(rdy), .busy(bsy), .valid_out(vo),
    .data_out(dout), .sat_flag(sat), .len_err(lerr)
  );

  neuron_mac #(.MAX_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .valid_in(valid_in), .data_in(data_in), .weight_in(weight_in),
    .last_in(last_in), .ready_in(rdy4), .busy(bsy4), .valid_out(vo4),
    .data_out(dout4), .sat_flag(sat4), .len_err(lerr4)
  );

  // Dot product from first principles: Q12.20 sum, 40-bit wrap, round, clamp.
  function automatic void ref_mac(input logic [15:0] b, input int n,
                                  output logic [15:0] q, output logic s);
    longint acc, r;
    acc = longint'($signed(b)) <<< 10;
    for (int i = 0; i < n; i++)
      acc += longint'($signed(md[i])) * longint'($signed(mw[i]));
    acc = (acc <<< 24) >>> 24;
    r = (acc + 512) >>> 10;
    s = 1'b1;
    if (r > 32767)       q = 16'h7FFF;
    else if (r < -32768) q = 16'h8000;
    else begin q = r[15:0]; s = 1'b0; end
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_start(input logic [15:0] b);
    start = 1'b1; bias_in = b; tick; start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [15:0] w, input logic l);
    valid_in = 1'b1; data_in = d; weight_in = w; last_in = l;
    tick;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask

  // Observes one result: cycles from the last-beat edge until valid_out,
  // the result fields, and the state one cycle later. lat=-1 on timeout.
  task automatic collect(input bit sel4, output int lat, output logic [15:0] d,
                         output logic s, output logic l, output logic vo_after,
                         output logic s_after, output logic l_after,
                         output logic [15:0] d_after);
    lat = 0;
    while (!(sel4 ? vo4 : vo) && lat < 10) begin tick; lat++; end
    if (!(sel4 ? vo4 : vo)) lat = -1;
    d = sel4 ? dout4 : dout; s = sel4 ? sat4 : sat; l = sel4 ? lerr4 : lerr;
    tick;
    vo_after = sel4 ? vo4 : vo;
    s_after = sel4 ? sat4 : sat; l_after = sel4 ? lerr4 : lerr;
    d_after = sel4 ? dout4 : dout;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; valid_in = 1'b1; last_in = 1'b1;
    bias_in = 16'h1234; data_in = 16'h0400; weight_in = 16'h0400;
    idle(2);
    checks++; if (vo !== 1'b0)  begin errors++; $display("FAIL reset_valid_out got=%b exp=0", vo); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0000", dout); end
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bsy); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rdy); end
    checks++; if ({sat, lerr} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {sat, lerr}); end
    rst = 1'b0; start = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    tick;
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_idle_after got=%b exp=0", bsy); end
  endtask

  task automatic test_basic;
    int lat; logic [15:0] d, da; logic s, l, va, sa, la;
    send_start(16'h0400);
    checks++; if (rdy !== 1'b1 || bsy !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b%b exp=11", rdy, bsy); end
    send_beat(16'h0800, 16'h0200, 1'b0);
    send_beat(16'h0400, 16'hFC00, 1'b1);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_ready_scale got=%b exp=0", rdy); end
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_latency got=%0d exp=1", lat); end
    checks++; if (d !== 16'h0400) begin errors++; $display("FAIL basic_data got=%h exp=0400", d); end
    checks++; if (s !== 1'b0 || l !== 1'b0) begin errors++; $display("FAIL basic_flags got=%b%b exp=00", s, l); end
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b exp=0", va); end
    checks++; if (da !== 16'h0400) begin errors++; $display("FAIL basic_hold got=%h exp=0400", da); end
  endtask

  task automatic test_saturation;
    int lat; logic [15:0] d, da; logic s, l, va, sa, la;
    send_start(16'h7FFF);
    send_beat(16'h7FFF, 16'h7FFF, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h7FFF || s !== 1'b1) begin errors++; $display("FAIL sat_pos got=%h/%b exp=7fff/1", d, s); end
    checks++; if (sa !== 1'b0) begin errors++; $display("FAIL sat_clear got=%b exp=0", sa); end
    send_start(16'h0000);
    send_beat(16'h8000, 16'h7FFF, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h8000 || s !== 1'b1) begin errors++; $display("FAIL sat_neg got=%h/%b exp=8000/1", d, s); end
  endtask

  task automatic test_rounding;
    int lat; logic [15:0] d, da; logic s, l, va, sa, la;
    send_start(16'h0000);
    send_beat(16'h0001, 16'h0200, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h0001 || s !== 1'b0) begin errors++; $display("FAIL round_up got=%h/%b exp=0001/0", d, s); end
    send_start(16'h0000);
    send_beat(16'h0001, 16'hFE00, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h0000 || s !== 1'b0) begin errors++; $display("FAIL round_neg_half got=%h/%b exp=0000/0", d, s); end
  endtask

  task automatic test_gaps_ignore;
    int lat; logic [15:0] d, da; logic s, l, va, sa, la;
    send_beat(16'h7FFF, 16'h7FFF, 1'b1);
    send_beat(16'h7FFF, 16'h7FFF, 1'b0);
    checks++; if (bsy !== 1'b0 || vo !== 1'b0) begin errors++; $display("FAIL ignore_idle_valid got=%b%b exp=00", bsy, vo); end
    send_start(16'h0000);
    send_beat(16'h0400, 16'h0400, 1'b0);
    idle(3);
    start = 1'b1; bias_in = 16'h7FFF; tick; start = 1'b0;
    checks++; if (bsy !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL gap_still_accum got=%b%b exp=11", bsy, rdy); end
    send_beat(16'h0400, 16'h0400, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h0800 || lat !== 1) begin errors++; $display("FAIL gap_result got=%h lat=%0d exp=0800 lat=1", d, lat); end
  endtask

  task automatic test_len_guard;
    int lat; logic [15:0] d, da; logic s, l, va, sa, la;
    send_start(16'h0000);
    for (int i = 0; i < 4; i++) send_beat(16'h0400, 16'h0400, 1'b0);
    collect(1'b1, lat, d, s, l, va, sa, la, da);
    checks++; if (lat !== 1) begin errors++; $display("FAIL len_latency got=%0d exp=1", lat); end
    checks++; if (d !== 16'h1000 || l !== 1'b1) begin errors++; $display("FAIL len_result got=%h/%b exp=1000/1", d, l); end
    checks++; if (la !== 1'b0) begin errors++; $display("FAIL len_clear got=%b exp=0", la); end
    valid_in = 1'b1; data_in = 16'h0400; weight_in = 16'h0400;
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL len_5th_ready got=%b exp=0", rdy4); end
    tick; valid_in = 1'b0;
    idle(3);
    checks++; if (bsy4 !== 1'b0 || dout4 !== 16'h1000) begin errors++; $display("FAIL len_5th_ignored got=%b/%h exp=0/1000", bsy4, dout4); end
    // Last on the guard beat: len_err must stay low.
    rst = 1'b1; tick; rst = 1'b0;
    send_start(16'h0000);
    for (int i = 0; i < 4; i++) send_beat(16'h0400, 16'h0400, i == 3);
    collect(1'b1, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h1000 || l !== 1'b0) begin errors++; $display("FAIL len_last_on_guard got=%h/%b exp=1000/0", d, l); end
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat, pulses; logic [15:0] d, da; logic s, l, va, sa, la;
    send_start(16'h0400);
    send_beat(16'h0400, 16'h0400, 1'b0);
    send_beat(16'h0400, 16'h0400, 1'b0);
    rst = 1'b1; valid_in = 1'b1; last_in = 1'b1; tick;
    rst = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin if (vo) pulses++; tick; end
    checks++; if (pulses !== 0 || bsy !== 1'b0) begin errors++; $display("FAIL rstmid_abort got=%0d/%b exp=0/0", pulses, bsy); end
    send_start(16'h0000);
    send_beat(16'h0000, 16'h0000, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h0000 || lat !== 1) begin errors++; $display("FAIL rstmid_new got=%h lat=%0d exp=0000 lat=1", d, lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] d, da; logic s, l, va, sa, la;
    send_start(16'h0400);
    send_beat(16'h0400, 16'h0400, 1'b1);
    tick;
    checks++; if (vo !== 1'b1 || dout !== 16'h0800) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/0800", vo, dout); end
    send_start(16'hFC00);
    checks++; if (bsy !== 1'b1 || vo !== 1'b0) begin errors++; $display("FAIL b2b_restart got=%b%b exp=10", bsy, vo); end
    send_beat(16'h0800, 16'h0800, 1'b1);
    collect(1'b0, lat, d, s, l, va, sa, la, da);
    checks++; if (d !== 16'h0C00 || lat !== 1) begin errors++; $display("FAIL b2b_second got=%h lat=%0d exp=0c00 lat=1", d, lat); end
  endtask

  task automatic test_random;
    int lat, n; logic [15:0] b, d, da, eq; logic s, l, va, sa, la, es;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 8);
      b = 16'($urandom);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          md[i] = 16'($urandom); mw[i] = 16'($urandom);
        end else begin
          md[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
          mw[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
        end
      end
      ref_mac(b, n, eq, es);
      send_start(b);
      for (int i = 0; i < n; i++) begin
        idle($urandom_range(0, 2));
        send_beat(md[i], mw[i], i == n - 1);
      end
      collect(1'b0, lat, d, s, l, va, sa, la, da);
      checks++;
      if (lat !== 1 || d !== eq || s !== es || l !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d got=%h sat=%b len=%b lat=%0d exp=%h sat=%b len=0 lat=1",
                 t, d, s, l, lat, eq, es);
      end
      rst = 1'b1; tick; rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    bias_in = '0; data_in = '0; weight_in = '0;
    test_reset;
    test_basic;
    test_saturation;
    test_rounding;
    test_gaps_ignore;
    test_back_to_back;
    test_len_guard;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
